// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// Serial UART transmitter, 8N1, LSB first. Frames are requested through a
// level-sensitive start input and timed by a fixed clocks-per-bit parameter.
// All outputs are registered.
//
// Ports
//   clk       in   1          system clock, rising edge
//   rst       in   1          asynchronous reset, active high
//   tx_en     in   1          enable; gates acceptance of new frames only
//   tx_rst    in   1          synchronous soft reset / abort, active high
//   tx_start  in   1          frame request, level sensitive
//   tx_data   in   DATA_BITS  payload, sampled in the acceptance cycle only
//   tx        out  1          serial line, idles high
//   tx_busy   out  1          high while a frame is on the line
//   tx_done   out  1          one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module uart_tx_core #(
   parameter int CLKS_PER_BIT = 651,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_en,
   input  logic                 tx_rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e                 state_q,    state_d;
   logic [CW-1:0]          baud_cnt_q, baud_cnt_d;
   logic [IW-1:0]          bit_idx_q,  bit_idx_d;
   logic [DATA_BITS-1:0]   shift_q,    shift_d;
   logic                   tx_q,       tx_d;
   logic                   busy_q,     busy_d;
   logic                   done_q,     done_d;

   // Last clock of the current bit period.
   logic bit_end;
   assign bit_end = (baud_cnt_q == BAUD_LAST);

   // -------------------------------------------------------------------------
   // Next-state and registered-output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves a
      // variable unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
            if (tx_start && tx_en) begin
               shift_d = tx_data;
               state_d = S_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               state_d    = S_DATA;
               tx_d       = shift_q[0];
            end else begin
               baud_cnt_d = baud_cnt_q + CW'(1);
            end
         end

         S_DATA: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               if (bit_idx_q == IDX_LAST) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  // The bit following the current one becomes the new LSB.
                  bit_idx_d = bit_idx_q + IW'(1);
                  shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                  tx_d      = shift_q[1];
               end
            end else begin
               baud_cnt_d = baud_cnt_q + CW'(1);
            end
         end

         S_STOP: begin
            if (bit_end) begin
               baud_cnt_d = '0;
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               done_d     = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + CW'(1);
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Soft abort overrides everything, including a simultaneous start
      // request, and deliberately suppresses the done pulse.
      if (tx_rst) begin
         state_d    = S_IDLE;
         baud_cnt_d = '0;
         bit_idx_d  = '0;
         shift_d    = '0;
         tx_d       = 1'b1;
         busy_d     = 1'b0;
         done_d     = 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its _d, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
// Self-checking bench for uart_tx_core with CLKS_PER_BIT = 4. Expected line
// behaviour comes from a frame-timeline model: given the payload and the
// number of cycles since acceptance, it returns {tx, tx_busy, tx_done}.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

   localparam int C  = 4;
   localparam int DB = 8;
   localparam int FRAME_LEN = 10 * C;   // cycles with tx_busy high

   logic          clk = 1'b0;
   logic          rst;
   logic          tx_en;
   logic          tx_rst;
   logic          tx_start;
   logic [DB-1:0] tx_data;
   logic          tx;
   logic          tx_busy;
   logic          tx_done;

   int checks   = 0;
   int failures = 0;

   uart_tx_core #(
      .CLKS_PER_BIT(C),
      .DATA_BITS   (DB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tx_en   (tx_en),
      .tx_rst  (tx_rst),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx      (tx),
      .tx_busy (tx_busy),
      .tx_done (tx_done)
   );

   always #5 clk = ~clk;

   // Move to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: {tx, busy, done} at cycle n after acceptance (n = 0 is
   // the acceptance cycle). Start bit, 8 data bits LSB first, stop bit, then
   // the done cycle; everything else is idle-high.
   function automatic logic [2:0] exp_out(input logic [DB-1:0] d, input int n);
      int k;
      if (n >= 1 && n <= C)                 return 3'b010;
      if (n > C && n <= 9 * C) begin
         k = (n - 1) / C - 1;
         return {d[k], 2'b10};
      end
      if (n > 9 * C && n <= FRAME_LEN)      return 3'b110;
      if (n == FRAME_LEN + 1)               return 3'b101;
      return 3'b100;
   endfunction

   // -------------------------------------------------------------------------
   task automatic test_reset();
      logic [2:0] got;
      rst = 1'b1; tx_en = 1'b0; tx_rst = 1'b0; tx_start = 1'b0; tx_data = '0;
      #12;
      got = {tx, tx_busy, tx_done};
      checks++;
      if (got !== 3'b100) begin
         failures++;
         $display("FAIL reset_values got=%b exp=100", got);
      end
      // Start held high with the transmitter disabled must never start a frame.
      tx_start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick();
         got = {tx, tx_busy, tx_done};
         checks++;
         if (got !== 3'b100) begin
            failures++;
            $display("FAIL disabled_idle n=%0d got=%b exp=100", n, got);
         end
      end
      tx_start = 1'b0;
      tick();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_single_frames();
      logic [DB-1:0] d;
      logic [2:0]    got, exp;
      for (int f = 0; f < 4; f++) begin
         d = (f == 0) ? 8'hA5 : DB'($urandom);
         tx_en = 1'b1; tx_data = d; tx_start = 1'b1;
         for (int n = 1; n <= FRAME_LEN + 3; n++) begin
            tick();
            tx_start = 1'b0;
            tx_data  = DB'($urandom);    // must not disturb the frame in flight
            got = {tx, tx_busy, tx_done};
            exp = exp_out(d, n);
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL single_frame data=%h n=%0d got=%b exp=%b", d, n, got, exp);
            end
         end
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_back_to_back();
      logic [DB-1:0] d1, d2;
      logic [2:0]    got, exp;
      for (int p = 0; p < 2; p++) begin
         d1 = (p == 0) ? 8'h00 : DB'($urandom);
         d2 = (p == 0) ? 8'hFF : DB'($urandom);
         tx_en = 1'b1; tx_data = d1; tx_start = 1'b1;
         for (int n = 1; n <= 2 * (FRAME_LEN + 1) + 2; n++) begin
            tick();
            if (n == 5) tx_data = d2;      // sampled at the second acceptance
            if (n == FRAME_LEN + 2) tx_start = 1'b0;
            got = {tx, tx_busy, tx_done};
            exp = (n <= FRAME_LEN + 1) ? exp_out(d1, n)
                                       : exp_out(d2, n - (FRAME_LEN + 1));
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL back_to_back pass=%0d n=%0d got=%b exp=%b", p, n, got, exp);
            end
         end
      end
   endtask

   // -------------------------------------------------------------------------
   // Start pulse during DATA is ignored; tx_en dropping mid-frame lets the
   // frame finish but blocks any new acceptance.
   task automatic test_ignore_and_enable();
      logic [DB-1:0] d;
      logic [2:0]    got, exp;
      d = DB'($urandom);
      tx_en = 1'b1; tx_data = d; tx_start = 1'b1;
      for (int n = 1; n <= FRAME_LEN + 10; n++) begin
         tick();
         tx_start = (n == 15);
         if (n == 15) tx_data = ~d;
         got = {tx, tx_busy, tx_done};
         exp = exp_out(d, n);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL busy_ignore n=%0d got=%b exp=%b", n, got, exp);
         end
      end
      d = DB'($urandom);
      tx_data = d; tx_start = 1'b1;
      for (int n = 1; n <= FRAME_LEN + 15; n++) begin
         tick();
         if (n == 10) tx_en = 1'b0;     // start stays high from here on
         got = {tx, tx_busy, tx_done};
         exp = exp_out(d, n);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL en_drop n=%0d got=%b exp=%b", n, got, exp);
         end
      end
      tx_start = 1'b0; tx_en = 1'b1;
      tick();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_soft_abort();
      logic [DB-1:0] d;
      logic [2:0]    got, exp;
      d = 8'h3C;
      tx_en = 1'b1; tx_data = d; tx_start = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         tick();
         // Third data bit spans cycles 3C+1..4C; abort inside it while start
         // is also requested, which the abort must override.
         tx_start = (n == 3 * C + 2);
         tx_rst   = (n == 3 * C + 2);
         exp = (n <= 3 * C + 2) ? exp_out(d, n) : 3'b100;
         got = {tx, tx_busy, tx_done};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL soft_abort n=%0d got=%b exp=%b", n, got, exp);
         end
      end
      d = DB'($urandom);
      tx_data = d; tx_start = 1'b1;
      for (int n = 1; n <= FRAME_LEN + 2; n++) begin
         tick();
         tx_start = 1'b0;
         got = {tx, tx_busy, tx_done};
         exp = exp_out(d, n);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL after_abort n=%0d got=%b exp=%b", n, got, exp);
         end
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_async_reset();
      logic [DB-1:0] d;
      logic [2:0]    got, exp;
      d = DB'($urandom);
      tx_en = 1'b1; tx_data = d; tx_start = 1'b1;
      for (int n = 1; n <= 9 * C + 2; n++) begin
         tick();
         tx_start = 1'b0;
         got = {tx, tx_busy, tx_done};
         exp = exp_out(d, n);
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL pre_reset n=%0d got=%b exp=%b", n, got, exp);
         end
      end
      // Now in the stop bit; assert rst between edges.
      #2 rst = 1'b1;
      #1;
      got = {tx, tx_busy, tx_done};
      checks++;
      if (got !== 3'b100) begin
         failures++;
         $display("FAIL async_reset got=%b exp=100", got);
      end
      #1 rst = 1'b0;
      for (int n = 0; n < 2 * C; n++) begin
         tick();
         got = {tx, tx_busy, tx_done};
         checks++;
         if (got !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_idle n=%0d got=%b exp=100", n, got);
         end
      end
   endtask

   // -------------------------------------------------------------------------
   initial begin
      test_reset();
      test_single_frames();
      test_back_to_back();
      test_ignore_and_enable();
      test_soft_abort();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
